// File: rtl/lsh_pkg.sv
// Shared definitions for the LSH front end: base encoding, window geometry
// and the k-mer sequencer state type. Window geometry lives here so the
// sequencer, the hasher and anything else slicing windows agree on it.
package lsh_pkg;

    typedef logic [1:0] base_t;

    localparam base_t BASE_A = 2'd0;
    localparam base_t BASE_C = 2'd1;
    localparam base_t BASE_G = 2'd2;
    localparam base_t BASE_T = 2'd3;

    localparam int WINDOW_SIZE = 128;  // bases per window
    localparam int KMER_SIZE   = 16;   // bases per k-mer
    localparam int STRIDE      = 1;    // (WINDOW_SIZE-KMER_SIZE) must divide by STRIDE

    localparam int NUM_KMERS = (WINDOW_SIZE - KMER_SIZE) / STRIDE + 1;
    localparam int POS_W     = $clog2(WINDOW_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/kmer_sequencer_if.sv
// Bundle between the input handler / hasher side and the k-mer sequencer.
//   master : the sequencer (accepts windows, offers k-mers, reports status)
//   slave  : the environment (offers windows, accepts k-mers, retires them)
// Signals:
//   window_valid/window_ready/window_data/window_id_in/is_insert_in - window offer
//   kmer_valid/kmer_ready/kmer_data/kmer_pos/kmer_window_id/
//   kmer_is_insert/kmer_last                                        - k-mer issue
//   hash_done     - one-cycle pulse per retired k-mer
//   window_done   - one-cycle pulse once a window is fully hashed
//   busy          - sequencer not idle
//   err_spurious  - sticky, hash_done seen with nothing outstanding
interface kmer_sequencer_if
    import lsh_pkg::*;
#(
    parameter int ID_W = 8
);
    logic                     window_valid;
    logic                     window_ready;
    logic [2*WINDOW_SIZE-1:0] window_data;
    logic [ID_W-1:0]          window_id_in;
    logic                     is_insert_in;
    logic                     kmer_valid;
    logic                     kmer_ready;
    logic [2*KMER_SIZE-1:0]   kmer_data;
    logic [POS_W-1:0]         kmer_pos;
    logic [ID_W-1:0]          kmer_window_id;
    logic                     kmer_is_insert;
    logic                     kmer_last;
    logic                     hash_done;
    logic                     window_done;
    logic                     busy;
    logic                     err_spurious;

    modport master (
        input  window_valid, window_data, window_id_in, is_insert_in,
               kmer_ready, hash_done,
        output window_ready, kmer_valid, kmer_data, kmer_pos, kmer_window_id,
               kmer_is_insert, kmer_last, window_done, busy, err_spurious
    );

    modport slave (
        output window_valid, window_data, window_id_in, is_insert_in,
               kmer_ready, hash_done,
        input  window_ready, kmer_valid, kmer_data, kmer_pos, kmer_window_id,
               kmer_is_insert, kmer_last, window_done, busy, err_spurious
    );
endinterface

// File: rtl/kmer_extract.sv
// Combinational k-mer slicer: returns KMER_SIZE bases starting at base index
// pos of a packed window (base i at bits [2i+1:2i]); base pos lands at LSBs.
// Ports:
//   window - packed window register
//   pos    - start base index, never beyond WINDOW_SIZE-KMER_SIZE
//   kmer   - selected k-mer
module kmer_extract
    import lsh_pkg::*;
(
    input  logic [2*WINDOW_SIZE-1:0] window,
    input  logic [POS_W-1:0]         pos,
    output logic [2*KMER_SIZE-1:0]   kmer
);
    localparam int KW = 2 * KMER_SIZE;

    // Shift by 2*pos bits and keep the low KW bits; pos is bounded so the
    // slice never runs past the window.
    assign kmer = KW'(window >> {pos, 1'b0});

endmodule

// File: rtl/kmer_sequencer.sv
// Scheduler between the input handler and the LSH hash unit. Latches one
// window, walks every k-mer start position, issues each k-mer over a
// valid/ready handshake while bounding in-flight k-mers with a credit
// counter, and pulses window_done only after every issued k-mer retired.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - kmer_sequencer_if master modport (window in, k-mers out, status)
module kmer_sequencer
    import lsh_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_W            = 8
) (
    input  logic             clk,
    input  logic             rst,
    kmer_sequencer_if.master bus
);
    localparam int                 OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [POS_W-1:0]   LAST_POS = POS_W'(WINDOW_SIZE - KMER_SIZE);
    localparam logic [POS_W-1:0]   POS_STEP = POS_W'(STRIDE);
    localparam logic [OUT_W-1:0]   OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

    seq_state_t               state, state_nxt;
    logic [POS_W-1:0]         pos;
    logic [OUT_W-1:0]         outstanding, out_nxt;
    logic [2*WINDOW_SIZE-1:0] window_reg;
    logic [ID_W-1:0]          id_reg;
    logic                     ins_reg;
    logic                     err_reg;

    logic window_ready, kmer_valid, window_done;
    logic accept, hs, retire, spurious, at_last;

    assign accept  = window_ready & bus.window_valid;
    assign hs      = kmer_valid & bus.kmer_ready;
    assign at_last = (pos == LAST_POS);

    // A hash_done is only a retirement when there is something to retire,
    // counting a k-mer handed over in the same cycle; otherwise it is
    // flagged and the counter holds at zero.
    assign retire   = bus.hash_done & ((outstanding != '0) | hs);
    assign spurious = bus.hash_done & (outstanding == '0) & ~hs;
    assign out_nxt  = outstanding + OUT_W'(hs) - OUT_W'(retire);

    always_comb begin
        state_nxt    = state;
        window_ready = 1'b0;
        kmer_valid   = 1'b0;
        window_done  = 1'b0;
        case (state)
            IDLE: begin
                window_ready = 1'b1;
                if (bus.window_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                // Credit check only depends on registered state, so valid
                // cannot fall without a handshake.
                kmer_valid = (outstanding < OUT_MAX);
                if (kmer_valid && bus.kmer_ready && at_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_nxt == '0) state_nxt = DONE;
            end
            DONE: begin
                window_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pos         <= '0;
            outstanding <= '0;
            window_reg  <= '0;
            id_reg      <= '0;
            ins_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            if (spurious) err_reg <= 1'b1;
            if (accept) begin
                window_reg <= bus.window_data;
                id_reg     <= bus.window_id_in;
                ins_reg    <= bus.is_insert_in;
                pos        <= '0;
            end else if (hs) begin
                pos <= pos + POS_STEP;
            end
        end
    end

    kmer_extract u_extract (
        .window (window_reg),
        .pos    (pos),
        .kmer   (bus.kmer_data)
    );

    assign bus.window_ready   = window_ready;
    assign bus.kmer_valid     = kmer_valid;
    assign bus.kmer_pos       = pos;
    assign bus.kmer_window_id = id_reg;
    assign bus.kmer_is_insert = ins_reg;
    assign bus.kmer_last      = (state == ISSUE) & at_last;
    assign bus.window_done    = window_done;
    assign bus.busy           = (state != IDLE);
    assign bus.err_spurious   = err_reg;

endmodule

// File: doc/kmer_sequencer.md
Name: kmer_sequencer

Overview:
- Scheduler between the input handler and the LSH hash unit.
- Accepts one DNA window (WINDOW_SIZE 2-bit bases) with its id and insert/query flag.
- Walks every k-mer start position, issues each k-mer to the hasher over a valid/ready handshake, and bounds in-flight k-mers with a credit counter.
- Signals window completion only after the hasher has retired every issued k-mer.

Parameters:
WINDOW_SIZE, 128, bases per window
KMER_SIZE, 16, bases per k-mer
STRIDE, 1, base step between consecutive k-mer starts; (WINDOW_SIZE-KMER_SIZE) must be divisible by STRIDE
MAX_OUTSTANDING, 4, maximum k-mers issued but not yet retired by hash_done
ID_W, 8, window id width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
window_valid  in  1  window offered
window_ready  out  1  sequencer can accept a window
window_data  in  2*WINDOW_SIZE  base i at bits [2i+1:2i]
window_id_in  in  ID_W  id of offered window
is_insert_in  in  1  1 = insert into tables, 0 = query
kmer_valid  out  1  k-mer offered to hasher
kmer_ready  in  1  hasher accepts k-mer
kmer_data  out  2*KMER_SIZE  bases pos..pos+KMER_SIZE-1, base pos at LSBs
kmer_pos  out  POS_W=$clog2(WINDOW_SIZE)  start base index
kmer_window_id  out  ID_W  latched window id
kmer_is_insert  out  1  latched insert flag
kmer_last  out  1  current k-mer is the final one of the window
hash_done  in  1  one-cycle pulse, hasher retired one k-mer
window_done  out  1  one-cycle pulse, window fully hashed
busy  out  1  state != IDLE
err_spurious  out  1  sticky: hash_done seen with zero outstanding

Behaviour:
- NUM_KMERS = (WINDOW_SIZE-KMER_SIZE)/STRIDE + 1 (113 at defaults). Last pos = WINDOW_SIZE-KMER_SIZE.
- Reset:
  - State IDLE; pos, outstanding, window register, id and flag all 0.
  - All outputs 0 except window_ready=1.
  - Reset mid-window discards the window and clears err_spurious; late hash_done pulses after reset count as spurious.
- IDLE:
  - window_ready=1.
  - On window_valid at cycle T: latch data, id and flag; pos=0; go to ISSUE.
  - kmer_valid may first be 1 in cycle T+1.
- ISSUE:
  - kmer_valid = (outstanding < MAX_OUTSTANDING).
  - Handshake (valid & ready): pos += STRIDE, outstanding += 1.
  - Handshake with kmer_last=1: go to DRAIN.
  - kmer_data, kmer_pos and kmer_last stay stable while valid & !ready.
  - kmer_valid never drops without a handshake unless rst.
- DRAIN:
  - kmer_valid=0.
  - Go to DONE in the cycle the next-state outstanding equals 0, including when a hash_done this cycle takes it to 0.
- DONE: window_done=1 for exactly one cycle, then IDLE. window_ready=0 in DONE; it returns to 1 in IDLE.
- outstanding counter:
  - Width $clog2(MAX_OUTSTANDING+1).
  - Handshake and hash_done in the same cycle: net unchanged.
  - hash_done at outstanding=0 with no same-cycle handshake: counter holds at 0, err_spurious=1 until rst.
  - Counter never exceeds MAX_OUTSTANDING.
- window_ready=0 in ISSUE, DRAIN and DONE, so no window overlap. A new window may be accepted in the cycle after DONE.
- kmer_data is combinational from the latched window and pos; no arithmetic overflow because pos ≤ WINDOW_SIZE-KMER_SIZE.

Decomposition:
- Shared package lsh_pkg:
  - base_t (logic [1:0]) and base encoding constants A=0, C=1, G=2, T=3.
  - WINDOW_SIZE, KMER_SIZE and derived NUM_KMERS / POS_W localparams.
  - seq_state_t enum {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module kmer_extract: purely combinational; window register + pos -> kmer_data slice. Reused by the hasher model in the testbench.

Test Plan:
- Defaults, kmer_ready=1, hash_done one cycle after each handshake, window base i = i%4:
  - -> 113 handshakes, kmer_pos 0..112.
  - kmer_data at pos 5 = bases 1,2,3,0,... (LSB first).
  - kmer_last only at pos 112.
  - Single window_done pulse after the last hash_done.
- Hasher never pulses hash_done:
  - -> exactly 4 handshakes, then kmer_valid=0 and busy=1 indefinitely.
  - One hash_done pulse -> exactly one more handshake.
- kmer_ready held 0 for 10 cycles at pos 7 -> kmer_valid, kmer_data and kmer_pos stable over all 10 cycles; pos 7 issued once.
- Handshake and hash_done in the same cycle at outstanding=3 -> outstanding stays 3; no lost or extra credit; final window_done still occurs.
- rst asserted at pos 50 with 2 outstanding:
  - -> next cycle IDLE, window_ready=1, kmer_valid=0.
  - A following hash_done sets err_spurious=1.
  - A new window then starts from pos 0.
- Back-to-back windows with ids 3 and 4, window_valid held high:
  - -> id 4 accepted the cycle after window 3's window_done.
  - kmer_window_id and kmer_is_insert switch only at the new window's pos 0.
